// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//
// Instruction fetch stage in front of the core's decode/execute logic.
// - Generates word-aligned fetch addresses.
// - Issues them to a synchronous instruction memory with a one-cycle read latency.
// - Buffers returned words together with their PCs in a DEPTH-entry prefetch FIFO.
// - Presents the FIFO head to the core as a valid/ready instruction stream.
//
// A redirect from the core (taken branch or jump) does three things:
// - flushes the FIFO;
// - retargets the fetch PC;
// - discards any response that is still in flight.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
// - When defined, a response that arrives while the FIFO is empty is
//   presented on the instruction outputs in the same cycle.
// - If the core accepts it in that cycle, it never enters the FIFO.
// - When undefined, every instruction output comes straight from FIFO registers.
//
// Handshake semantics, both interfaces:
// - Memory side: a request transfers on a cycle where imem_req & imem_ready.
//   imem_addr is held stable while imem_req is high and imem_ready is low.
// - Memory side: read data is taken exactly one cycle after the transfer.
// - Core side: an instruction transfers on a cycle where instr_valid & instr_ready.
//   instr and instr_pc are held stable while instr_valid is high and instr_ready is low.

module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,

    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,

    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Fetch-side state
    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          kill;

    // Prefetch FIFO storage and bookkeeping
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    // Per-cycle control
    logic          fifo_empty;
    logic          resp_valid;
    logic          bypass_hit;
    logic          pop;
    logic          fifo_rd;
    logic          fifo_wr;
    logic          issue;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_target;
    logic [1:0]    unused_redirect_lsbs;

    // The two low bits of a redirect target are meaningless for
    // word-aligned fetch and are dropped here.
    assign unused_redirect_lsbs = redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[31:2], 2'b00};

    assign fifo_empty = (count == '0);

    // A response is only usable if it was not cancelled by a redirect
    // in the cycle it was in flight.
    assign resp_valid = inflight & ~kill;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = resp_valid & fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // Present the FIFO head, or the arriving response when it is bypassed.
    always_comb begin
        instr_valid = ~fifo_empty;
        instr       = word_mem[rd_ptr];
        instr_pc    = pc_mem[rd_ptr];
        if (bypass_hit) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = inflight_pc;
        end
    end

    assign pop = instr_valid & instr_ready;

    // Consumption and allocation decisions.
    // Redirect overrides both: the pop is ignored and the response is discarded.
    // A bypassed response that is consumed on arrival never occupies a slot.
    // fifo_rd needs a non-empty FIFO, so a bypassed pop never reads storage.
    always_comb begin
        fifo_rd = pop & ~fifo_empty & ~redirect;
        fifo_wr = resp_valid & ~redirect & ~(bypass_hit & instr_ready);
    end

    // Projected occupancy if another request were issued now.
    // - Counts the entries held in the FIFO.
    // - Adds the response currently landing.
    // - Subtracts the entry leaving this cycle.
    // Keeping it below DEPTH guarantees every issued response has a slot.
    always_comb begin
        occupancy = {1'b0, count}
                  + {{CW{1'b0}}, inflight}
                  - {{CW{1'b0}}, pop};
        imem_req  = ~reset & ~redirect & (occupancy < DEPTH_W);
    end

    assign imem_addr = fetch_pc;
    assign issue     = imem_req & imem_ready;

    // Fetch PC, outstanding-request tracking and response kill.
    // - The fetch PC advances only on an accepted issue.
    // - A redirect overrides any issue.
    // - At most one request is outstanding at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
        end else begin
            // Kill lasts exactly one cycle and only matters if a request
            // was outstanding when the redirect arrived.
            kill     <= redirect & inflight;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // FIFO pointers and entry count.
    // A redirect empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage.
    // It is cleared on reset so that the instruction outputs read as zero
    // before the first fetch lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                word_mem[i] <= '0;
            end
        end else if (fifo_wr) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            word_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit
//
// Directed scenarios for fetch_prefetch_unit in its default build.
// - The memory model returns a word derived from the fetched address.
// - Every consumed instruction is matched against an expected queue of {pc, word}.
// - Cycle-exact points are checked inline in each scenario.

module tb_fetch_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    fetch_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    // Word k lives at address 4k, tagged so words are not equal to their PCs.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'hA5A5_0000;
    endfunction

    // Data is valid only the cycle after an accepted request; otherwise garbage.
    always @(posedge clk) begin
        if (imem_req && imem_ready) imem_rdata <= mem_word(imem_addr);
        else                        imem_rdata <= 32'hDEAD_BEEF;
    end

    // ---------------- driver tasks ----------------
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({pc, mem_word(pc)});
            pc = pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        imem_ready  = 1'b1;
        advance();
        advance();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- scoreboard ----------------
    // Sample mid-cycle; a consumed instruction must match the expected queue head.
    // Pops under redirect are discarded by the design and are not consumed.
    task automatic observe();
        logic [63:0] e;
        @(negedge clk);
        if (instr_valid && instr_ready && !redirect && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got pc=%h instr=%h, expected no instruction", instr_pc, instr);
            end else begin
                e = exp_q.pop_front();
                if ({instr_pc, instr} !== e) begin
                    errors++;
                    $display("FAIL sb_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                             instr_pc, instr, e[63:32], e[31:0]);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        instr_ready = 1'b1;
        imem_ready  = 1'b1;
        advance();
        advance();
        observe();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h expected %h", imem_addr, RESET_PC); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", instr_pc); end
        advance();
        reset    = 1'b0;
        redirect = 1'b0;
        observe();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL rst_first_fetch: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        push_seq(32'h0, 10);
        for (int k = 0; k < 12; k++) begin
            observe();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_addr: cycle %0d got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
            end
            checks++;
            if (instr_valid !== 1'(k >= 2)) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d got %b expected %b", k, instr_valid, 1'(k >= 2));
            end
            if (k == 2) begin
                checks++;
                if (instr_pc !== 32'h0) begin errors++; $display("FAIL stream_first_pc: got %h expected 0", instr_pc); end
            end
            advance();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int issues;
        issues = 0;
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            observe();
            if (imem_req && imem_ready) issues++;
            if (k == 9) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stop: got %b expected 0", imem_req); end
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=0", instr_valid, instr_pc);
                end
            end
            advance();
        end
        checks++;
        if (issues != DEPTH) begin errors++; $display("FAIL bp_issues: got %0d expected %0d", issues, DEPTH); end
        push_seq(32'h0, 8);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            observe();
            checks++;
            if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_throughput: cycle %0d got valid=%b expected 1", k, instr_valid); end
            if (k == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                    errors++;
                    $display("FAIL bp_resume_addr: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr);
                end
            end
            advance();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        push_seq(32'h0, 3);
        redirect_pc = 32'h0000_0103;
        for (int k = 0; k < 12; k++) begin
            redirect = (k == 5);
            observe();
            if (k == 4) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                    errors++;
                    $display("FAIL rdi_pre_addr: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr);
                end
            end
            if (k == 5) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdi_no_issue: got %b expected 0", imem_req); end
                exp_q.delete();
                push_seq(32'h100, 4);
            end
            if (k == 6) begin
                checks++;
                if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                    errors++;
                    $display("FAIL rdi_restart: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=100", instr_valid, imem_req, imem_addr);
                end
            end
            if (k == 7) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdi_gap: got %b expected 0", instr_valid); end
            end
            if (k == 8) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
                    errors++;
                    $display("FAIL rdi_latency: got valid=%b pc=%h expected valid=1 pc=100", instr_valid, instr_pc);
                end
            end
            advance();
        end
        redirect = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rdi_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_imem_stall();
        do_reset();
        push_seq(32'h0, 13);
        for (int k = 0; k < 18; k++) begin
            imem_ready = !(k >= 8 && k <= 10);
            observe();
            if (k >= 8 && k <= 11) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
                    errors++;
                    $display("FAIL stall_hold: cycle %0d got req=%b addr=%h expected req=1 addr=20", k, imem_req, imem_addr);
                end
            end
            if (k >= 10 && k <= 12) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble: cycle %0d got %b expected 0", k, instr_valid); end
            end
            if (k == 13) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h20) begin
                    errors++;
                    $display("FAIL stall_resume: got valid=%b pc=%h expected valid=1 pc=20", instr_valid, instr_pc);
                end
            end
            advance();
        end
        imem_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_full_pop();
        do_reset();
        redirect_pc = 32'h0000_0200;
        for (int k = 0; k < 13; k++) begin
            instr_ready = (k >= 6);
            redirect    = (k == 6);
            observe();
            if (k == 5) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL full_pre: got valid=%b pc=%h req=%b expected valid=1 pc=0 req=0", instr_valid, instr_pc, imem_req);
                end
            end
            if (k == 6) begin
                exp_q.delete();
                push_seq(32'h200, 4);
            end
            if (k == 7) begin
                checks++;
                if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL full_flush: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=200", instr_valid, imem_req, imem_addr);
                end
            end
            if (k == 9) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
                    errors++;
                    $display("FAIL full_restart: got valid=%b pc=%h expected valid=1 pc=200", instr_valid, instr_pc);
                end
            end
            advance();
        end
        redirect = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_seq(32'h0, 3);
        for (int k = 0; k < 13; k++) begin
            redirect    = (k == 5) || (k == 6);
            redirect_pc = (k == 5) ? 32'h0000_0300 : 32'h0000_0401;
            observe();
            if (k == 5) begin
                exp_q.delete();
                push_seq(32'h400, 4);
            end
            if (k == 6) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_no_issue: got %b expected 0", imem_req); end
            end
            if (k == 7) begin
                checks++;
                if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin
                    errors++;
                    $display("FAIL b2b_target: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=400", instr_valid, imem_req, imem_addr);
                end
            end
            if (k == 9) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h400) begin
                    errors++;
                    $display("FAIL b2b_first: got valid=%b pc=%h expected valid=1 pc=400", instr_valid, instr_pc);
                end
            end
            advance();
        end
        redirect = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_pc = 32'hFFFF_FFF8;
        push_seq(32'hFFFF_FFF8, 4);
        for (int k = 0; k < 7; k++) begin
            redirect = (k == 0);
            observe();
            if (k == 2) begin
                checks++;
                if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr_fc: got %h expected fffffffc", imem_addr); end
            end
            if (k == 3) begin
                checks++;
                if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr_0: got %h expected 0", imem_addr); end
            end
            advance();
        end
        redirect = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        imem_ready  = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_imem_stall();
        test_redirect_full_pop();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Instruction fetch stage that sits directly upstream of the RISC-V core's decode/execute logic. It generates word-aligned fetch addresses, issues them to a synchronous instruction memory with one-cycle read latency, and buffers returned words with their PCs in a small prefetch FIFO. It also provides a valid/ready instruction stream to the core. Taken branches and jumps from the core redirect the stream: the FIFO is flushed, and any in-flight response is discarded.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  fetch address, bits [1:0] always 0
- imem_ready  in  1  memory accepts request; issue = imem_req & imem_ready
- imem_rdata  in  32  read data, valid exactly one cycle after an issue
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr_ready  in  1  core consumes; pop = instr_valid & instr_ready
- instr  out  32  instruction word
- instr_pc  out  32  address instr was fetched from
- redirect  in  1  taken branch/jump from core
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated 0)

## Operation
- State: fetch_pc (32), FIFO of {pc, word} × DEPTH, count (0..DEPTH), inflight flag plus inflight_pc (one outstanding request max), kill flag.
- Issue rule: imem_req = ~reset & ~redirect & (count + inflight − pop < DEPTH). imem_addr = fetch_pc. On issue: fetch_pc += 4 (wraps modulo 2^32), inflight set, inflight_pc = fetch_pc.
- Response: cycle after issue, if kill clear, push {inflight_pc, imem_rdata}; inflight clears. Simultaneous push and pop allowed at any count, including full (pop frees the slot).
- Output: instr/instr_pc = FIFO head; instr_valid = count != 0. Head is stable while instr_valid & ~instr_ready.
- Redirect (highest priority): count → 0, fetch_pc ← {redirect_pc[31:2], 2'b00}, no issue that cycle, and any pop that cycle is ignored. If a request is in flight, kill is set so the response arriving next cycle is discarded; kill clears after that cycle. First new request is issued on the cycle after redirect.
- Back-to-back redirects: each one overrides; only the last redirect_pc is fetched.
- imem_ready low: imem_req holds with the same imem_addr; fetch_pc does not advance.

## Timing
- Reset values: instr_valid 0, instr 0, instr_pc 0, imem_req 0, imem_addr RESET_PC, count 0, inflight 0, kill 0. Redirect during reset is ignored.
- First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
- Latency issue→instr_valid: 2 cycles (response cycle + FIFO write).
- Latency redirect→first new instr_valid: 3 cycles.
- Sustained throughput: 1 instruction/cycle with instr_ready and imem_ready held high.
- Backpressure: with instr_ready low, issues stop once count + inflight = DEPTH. No response is ever dropped except by kill.

## Configuration
- FETCH_BYPASS_EN defined: a response arriving when count = 0 is presented on instr/instr_pc/instr_valid combinationally in the response cycle. If popped that cycle, it is not written to the FIFO. This gives issue→valid latency of 1 and redirect→valid latency of 2.
- Without FETCH_BYPASS_EN: all outputs come from FIFO registers, and latencies are as in Timing.

## Test plan
- Reset release with RESET_PC=0 and memory returning word k at address 4k: imem_addr 0,4,8,… on consecutive cycles; instr_valid first rises 2 cycles after reset deasserts with instr_pc=0; then instr_pc 0,4,8 on consecutive cycles.
- instr_ready low for 10 cycles, DEPTH=4: exactly 4 issues total, count=4, imem_req=0. Raising instr_ready yields instr_pc 0,4,8,12 in order, then streaming resumes at 16.
- Redirect to 32'h0000_0103 while a request to 0x10 is in flight: the 0x10 word is never presented, instr_valid drops the next cycle, next imem_addr=0x100, and the first instr_pc=0x100 appears 3 cycles after redirect.
- imem_ready low for 3 cycles at address 0x20: imem_req stays 1 with imem_addr=0x20 throughout; the first accepted issue returns data with instr_pc=0x20, and nothing is duplicated or skipped.
- Redirect with pop in the same cycle while FIFO is full: FIFO is empty the next cycle, the popped entry is not re-presented, and fetching restarts at redirect_pc.
- Wrap-around with RESET_PC=32'hFFFF_FFF8: instr_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
